// File: rtl/bpu_pkg.sv
// ============================================================================
// Module  : bpu_pkg
// Brief   : Shared BPU encodings and call/return classification helpers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bpu_pkg;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [4:0] REG_RA   = 5'd1;
  localparam logic [4:0] REG_T0   = 5'd5;

  typedef enum logic [1:0] {
    CR_NONE = 2'd0,
    CR_CALL = 2'd1,
    CR_RET  = 2'd2
  } cr_kind_t;

  // Link-register hint: x1 always, x5 only when the alternate link is enabled.
  function automatic logic is_link(input logic [4:0] r, input logic link_x5);
    return (r == REG_RA) || (link_x5 && (r == REG_T0));
  endfunction

endpackage

`default_nettype wire

// File: rtl/ras_link_classify.sv
// ============================================================================
// Module  : ras_link_classify
// Brief   : Combinational call/return classifier for a 32-bit RISC-V instr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ras_link_classify
  import bpu_pkg::*;
#(
  parameter bit LINK_X5 = 1'b1
) (
  input  logic        valid,
  input  logic [31:0] instr,
  output cr_kind_t    kind
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic       w_rd_link;
  logic       w_rs1_link;
  logic       w_unused;

  assign w_opcode   = instr[6:0];
  assign w_funct3   = instr[14:12];
  assign w_rd       = instr[11:7];
  assign w_rs1      = instr[19:15];
  assign w_rd_link  = is_link(w_rd, LINK_X5);
  assign w_rs1_link = is_link(w_rs1, LINK_X5);
  assign w_unused   = ^instr[31:20];

  // A link destination always wins: rd==rs1 and co-routine swaps push only.
  always_comb begin
    kind = CR_NONE;
    if (valid && (instr[1:0] == 2'b11)) begin
      if (w_opcode == OPC_JAL) begin
        if (w_rd_link) kind = CR_CALL;
      end else if ((w_opcode == OPC_JALR) && (w_funct3 == 3'b000)) begin
        if (w_rd_link)       kind = CR_CALL;
        else if (w_rs1_link) kind = CR_RET;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ras_call_ret_detect.sv
// ============================================================================
// Module  : ras_call_ret_detect
// Brief   : Pipelined call/return pre-decoder feeding the BPU return stack.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ras_call_ret_detect
  import bpu_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter bit LINK_X5 = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BPU__Stall,
  input  logic             Flush,
  input  logic             IF_Valid,
  input  logic [31:0]      IF_Instr,
  input  logic [31:0]      IF_PC,
  output logic             CALL_Inst,
  output logic [31:0]      CALL_Inst_nextPC,
  output logic             RET_Inst,
  output logic             RET_Inst_EX,
  output logic [CNT_W-1:0] Call_Count,
  output logic [CNT_W-1:0] Ret_Count
);

  localparam logic [31:0] c_INSTR_BYTES = 32'd4;

  cr_kind_t          w_kind;
  logic              r_id_call;
  logic              r_id_ret;
  logic [31:0]       r_id_npc;
  logic              r_ex_ret;
  logic [CNT_W-1:0]  r_call_cnt;
  logic [CNT_W-1:0]  r_ret_cnt;
  logic              w_advance;

  ras_link_classify #(
    .LINK_X5 (LINK_X5)
  ) u_classify (
    .valid (IF_Valid),
    .instr (IF_Instr),
    .kind  (w_kind)
  );

  assign w_advance = !BPU__Stall && !Flush;

  // Flush beats stall; nextPC is left alone on flush since flags are cleared.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_id_call <= 1'b0;
      r_id_ret  <= 1'b0;
      r_id_npc  <= 32'd0;
      r_ex_ret  <= 1'b0;
    end else if (Flush) begin
      r_id_call <= 1'b0;
      r_id_ret  <= 1'b0;
      r_ex_ret  <= 1'b0;
    end else if (!BPU__Stall) begin
      r_id_call <= (w_kind == CR_CALL);
      r_id_ret  <= (w_kind == CR_RET);
      r_ex_ret  <= r_id_ret;
      if (w_kind == CR_CALL) r_id_npc <= IF_PC + c_INSTR_BYTES;
    end
  end

  // Counting the registered ID flag only on advancing cycles means a held
  // pulse is counted exactly once, when it leaves ID.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_call_cnt <= '0;
      r_ret_cnt  <= '0;
    end else if (w_advance) begin
      if (r_id_call && (r_call_cnt != {CNT_W{1'b1}}))
        r_call_cnt <= r_call_cnt + CNT_W'(1);
      if (r_id_ret && (r_ret_cnt != {CNT_W{1'b1}}))
        r_ret_cnt <= r_ret_cnt + CNT_W'(1);
    end
  end

  assign CALL_Inst        = r_id_call;
  assign RET_Inst         = r_id_ret;
  assign CALL_Inst_nextPC = r_id_npc;
  assign RET_Inst_EX      = r_ex_ret;
  assign Call_Count       = r_call_cnt;
  assign Ret_Count        = r_ret_cnt;

endmodule

`default_nettype wire

// File: doc/ras_call_ret_detect.md
Name: ras_call_ret_detect

Overview:
Call/return pre-decoder sitting directly upstream of the BPU return address stack. It takes the fetched 32-bit RISC-V instruction and PC, classifies it as call, return or neither using the link-register hint rules, and produces the stack's CALL_Inst, CALL_Inst_nextPC, RET_Inst (ID stage) and RET_Inst_EX (EX stage) controls. Classification is pipelined in step with the core, so stalls and flushes keep it consistent with the instruction stream. It also keeps saturating call/return event counters for performance debug.

Parameters:
CNT_W, 16, width of Call_Count / Ret_Count
LINK_X5, 1, 1 = x5 is a link register as well as x1; 0 = x1 only

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
BPU__Stall  in  1  hold all pipeline registers
Flush  in  1  kill in-flight ID/EX classifications (redirect)
IF_Valid  in  1  IF_Instr/IF_PC valid this cycle
IF_Instr  in  32  fetched instruction
IF_PC  in  32  PC of IF_Instr
CALL_Inst  out  1  ID-stage instruction is a call (push)
CALL_Inst_nextPC  out  32  return address to push (ID PC + 4)
RET_Inst  out  1  ID-stage instruction is a return (pop)
RET_Inst_EX  out  1  EX-stage instruction is a return
Call_Count  out  CNT_W  saturating count of calls
Ret_Count  out  CNT_W  saturating count of returns

Behaviour:
- One clock (CLK); reset synchronous, active-high (RST). All outputs 0 after reset.
- link(r) = (r==1) | (LINK_X5 & r==5). rd=IF_Instr[11:7], rs1=IF_Instr[19:15].
- Combinational classify of IF_Instr (only if IF_Valid, IF_Instr[1:0]==2'b11):
  * JAL (opcode 1101111): call if link(rd); else none.
  * JALR (opcode 1100111, funct3 000): link(rd)&!link(rs1) -> call; !link(rd)&link(rs1) -> ret; link(rd)&link(rs1) -> call (covers rd==rs1 and rd!=rs1 co-routine case; no pop+push); neither -> none.
  * All other opcodes, funct3!=000 JALR, compressed encodings -> none. Call and ret never both 1.
- ID register (drives CALL_Inst, RET_Inst, CALL_Inst_nextPC), priority:
  1. RST -> clear.
  2. Flush -> CALL_Inst=RET_Inst=0 (overrides BPU__Stall); nextPC don't-care, hold it.
  3. BPU__Stall -> hold.
  4. else capture classification; CALL_Inst_nextPC <= IF_PC + 32'd4 (mod 2^32, wrap at 0xFFFFFFFC -> 0x0) only when call, else hold.
- EX register: RET_Inst_EX <= RET_Inst; same priority (Flush clears, stall holds). Latency: IF -> CALL/RET 1 cycle, -> RET_Inst_EX 2 cycles.
- Counters: on cycle with !RST & !BPU__Stall & !Flush, Call_Count += CALL_Inst, Ret_Count += RET_Inst; saturate at all-ones (no wrap). Cleared only by RST.
- Back-to-back calls/returns each produce a one-cycle pulse per non-stalled cycle; stall never duplicates or drops a pulse.
- RST mid-stream: next cycle all flags 0, counters 0, regardless of Stall/Flush.

Decomposition:
- Shared package bpu_pkg: OPC_JAL=7'b1101111, OPC_JALR=7'b1100111, REG_RA=5'd1, REG_T0=5'd5, enum cr_kind_t {CR_NONE, CR_CALL, CR_RET}.
- One combinational sub-module ras_link_classify (instr, valid -> cr_kind_t); the top holds ID/EX registers and counters.

Test Plan:
- IF_Instr=0x008000EF (jal ra,8), IF_PC=0x00001000, valid -> next cycle CALL_Inst=1, CALL_Inst_nextPC=0x00001004, RET_Inst=0; Call_Count 0->1 the cycle after.
- IF_Instr=0x00008067 (ret), valid -> RET_Inst=1 at +1, RET_Inst_EX=1 at +2, CALL_Inst=0; Ret_Count increments once.
- IF_Instr=0x000280E7 (jalr ra,0(t0)) -> CALL_Inst=1 only; with LINK_X5=0 same encoding -> CALL_Inst=1 (rd=x1 link, rs1 not); 0x0080006F (jal x0) -> no flags.
- ret captured in ID, BPU__Stall=1 for 3 cycles -> RET_Inst held 1, RET_Inst_EX unchanged, Ret_Count increments once only after stall drops.
- ret in ID, Flush=1 with BPU__Stall=1 -> next cycle RET_Inst=0, RET_Inst_EX=0, no counter change.
- Preload Call_Count to 0xFFFF via 65535 calls, one more call -> stays 0xFFFF; IF_PC=0xFFFFFFFC call -> nextPC=0x00000000.
